// File: rtl/wb_arbiter_pkg.sv
// Shared widths and defaults for the writeback arbiter and its scoreboard.
package wb_arbiter_pkg;
  localparam int XLEN             = 32;
  localparam int REG_ADDR_W       = 5;
  localparam int NUM_REGS         = 1 << REG_ADDR_W;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, x0 never pending.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t a_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      a_pend,
  output logic      rs1_pend,
  output logic      rs2_pend
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clear is applied first so a same-cycle set of the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign a_pend   = pending_q[a_addr];
  assign rs1_pend = pending_q[rs1_addr];
  assign rs2_pend = pending_q[rs2_addr];

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter (B = load return, A = execute) with anti-starvation
// for A, a load scoreboard and a registered single register-file write port.
// Handshake: a transfer happens on a requester when valid && ready at a rising edge;
// valid must not depend on ready, and at most one requester transfers per cycle.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      a_valid,
  output logic      a_ready,
  input  reg_addr_t a_addr,
  input  xdata_t    a_data,
  input  logic      b_valid,
  output logic      b_ready,
  input  reg_addr_t b_addr,
  input  xdata_t    b_data,
  input  logic      ld_issue,
  input  reg_addr_t ld_issue_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rf_wen,
  output reg_addr_t rf_waddr,
  output xdata_t    rf_wdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             a_pend, rs1_pend, rs2_pend;
  logic             a_forced, a_xfer, b_xfer;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rf_wen_q, rf_wen_d;
  reg_addr_t        rf_waddr_q, rf_waddr_d;
  xdata_t           rf_wdata_q, rf_wdata_d;

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (ld_issue),
    .set_addr (ld_issue_rd),
    .clr_en   (b_xfer),
    .clr_addr (b_addr),
    .a_addr   (a_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .a_pend   (a_pend),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend)
  );

  // A is held off by its own pending bit (WAW order) even while being forced.
  assign a_forced = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign b_ready  = !a_forced;
  assign a_ready  = !a_pend && (!b_valid || a_forced);
  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!a_valid || a_xfer)
      starve_cnt_d = '0;
    else if (!a_pend && b_valid && !a_forced)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Address and data hold unless a real (non-x0) write is launched.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (b_xfer && (b_addr != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = b_addr;
      rf_wdata_d = b_data;
    end else if (a_xfer && (a_addr != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = a_addr;
      rf_wdata_d = a_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // The write in flight is not yet visible in the register file.
  assign rs1_busy = rs1_pend || (rf_wen_q && (rf_waddr_q == rs1_addr) && (rs1_addr != '0));
  assign rs2_busy = rs2_pend || (rf_wen_q && (rf_waddr_q == rs2_addr) && (rs2_addr != '0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table, starvation sequence and mid-operation reset.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      a_valid, a_ready, b_valid, b_ready;
  reg_addr_t a_addr, b_addr, ld_issue_rd, rs1_addr, rs2_addr, rf_waddr;
  xdata_t    a_data, b_data, rf_wdata;
  logic      ld_issue, rs1_busy, rs2_busy, rf_wen;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        li;
    logic [4:0]  lr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ardy;
    logic        e_brdy;
    logic        e_r1b;
    logic        e_r2b;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic li, input logic [4:0] lr,
                       input logic [4:0] r1, input logic [4:0] r2);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    ld_issue = li; ld_issue_rd = lr;
    rs1_addr = r1; rs2_addr = r2;
  endtask

  // Called at a falling edge; checks combinational outputs, then the registered write.
  task automatic apply(input vec_t v);
    drive(v.av, v.aa, v.ad, v.bv, v.ba, v.bd, v.li, v.lr, v.r1, v.r2);
    #1;
    check({v.name, ".a_ready"},  32'(a_ready),  32'(v.e_ardy));
    check({v.name, ".b_ready"},  32'(b_ready),  32'(v.e_brdy));
    check({v.name, ".rs1_busy"}, 32'(rs1_busy), 32'(v.e_r1b));
    check({v.name, ".rs2_busy"}, 32'(rs2_busy), 32'(v.e_r2b));
    @(posedge clk); #1;
    check({v.name, ".rf_wen"},   32'(rf_wen),   32'(v.e_wen));
    check({v.name, ".rf_waddr"}, 32'(rf_waddr), 32'(v.e_wa));
    check({v.name, ".rf_wdata"}, rf_wdata,      v.e_wd);
    @(negedge clk);
  endtask

  initial begin
    //         name       av aa  ad            bv ba  bd          li lr  r1  r2   ardy brdy r1b r2b wen wa  wd
    vecs[0]  = '{"idle0",   0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0,  0,   1, 1, 0, 0,  0, 0,  32'h0};
    vecs[1]  = '{"a_only",  1, 5,  32'h1234,     0, 0,  32'h0,      0, 0,  5,  0,   1, 1, 0, 0,  1, 5,  32'h1234};
    vecs[2]  = '{"byp5",    0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  5,  0,   1, 1, 1, 0,  0, 5,  32'h1234};
    vecs[3]  = '{"ab_b",    1, 4,  32'hAAAA,     1, 3,  32'hBBBB,   0, 0,  3,  4,   0, 1, 0, 0,  1, 3,  32'hBBBB};
    vecs[4]  = '{"ab_a",    1, 4,  32'hAAAA,     0, 0,  32'h0,      0, 0,  3,  4,   1, 1, 1, 0,  1, 4,  32'hAAAA};
    vecs[5]  = '{"a_x0",    1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,      1, 0,  4,  0,   1, 1, 1, 0,  0, 4,  32'hAAAA};
    vecs[6]  = '{"x0_npend",0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0,  0,   1, 1, 0, 0,  0, 4,  32'hAAAA};
    vecs[7]  = '{"ld7",     0, 0,  32'h0,        0, 0,  32'h0,      1, 7,  7,  0,   1, 1, 0, 0,  0, 4,  32'hAAAA};
    vecs[8]  = '{"a7_blk",  1, 7,  32'h7777,     0, 0,  32'h0,      0, 0,  7,  0,   0, 1, 1, 0,  0, 4,  32'hAAAA};
    vecs[9]  = '{"b7_waw",  1, 7,  32'h7777,     1, 7,  32'h70,     0, 0,  7,  0,   0, 1, 1, 0,  1, 7,  32'h70};
    vecs[10] = '{"a7_go",   1, 7,  32'h7777,     0, 0,  32'h0,      0, 0,  7,  0,   1, 1, 1, 0,  1, 7,  32'h7777};
    vecs[11] = '{"byp7",    0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  7,  0,   1, 1, 1, 0,  0, 7,  32'h7777};
    vecs[12] = '{"free7",   0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  7,  0,   1, 1, 0, 0,  0, 7,  32'h7777};
    vecs[13] = '{"b_npend", 0, 0,  32'h0,        1, 9,  32'h99,     0, 0,  0,  0,   0, 1, 0, 0,  1, 9,  32'h99};
    vecs[14] = '{"setclr",  0, 0,  32'h0,        1, 10, 32'hA0,     1, 10, 10, 0,   0, 1, 0, 0,  1, 10, 32'hA0};
    vecs[15] = '{"set_won", 0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  10, 9,   1, 1, 1, 0,  0, 10, 32'hA0};
    vecs[16] = '{"b10",     0, 0,  32'h0,        1, 10, 32'hA1,     0, 0,  10, 0,   0, 1, 1, 0,  1, 10, 32'hA1};
    vecs[17] = '{"byp10",   0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  10, 0,   1, 1, 1, 0,  0, 10, 32'hA1};
    vecs[18] = '{"free10",  0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  10, 0,   1, 1, 0, 0,  0, 10, 32'hA1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst.rf_wen",   32'(rf_wen),   32'h0);
    check("rst.rf_waddr", 32'(rf_waddr), 32'h0);
    check("rst.rf_wdata", rf_wdata,      32'h0);
    check("rst.a_ready",  32'(a_ready),  32'h1);
    check("rst.b_ready",  32'(b_ready),  32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) apply(vecs[i]);

    // Starvation: both valid for 6 cycles; A is forced on the 5th.
    for (int i = 0; i < 6; i++) begin
      drive(1, 12, 32'hC0DE, 1, 13, 32'h100 + 32'(i), 0, 0, 0, 0);
      #1;
      check($sformatf("starve%0d.a_ready", i), 32'(a_ready), (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("starve%0d.b_ready", i), 32'(b_ready), (i == 4) ? 32'h0 : 32'h1);
      @(posedge clk); #1;
      check($sformatf("starve%0d.rf_wen", i), 32'(rf_wen), 32'h1);
      check($sformatf("starve%0d.rf_waddr", i), 32'(rf_waddr), (i == 4) ? 32'd12 : 32'd13);
      check($sformatf("starve%0d.rf_wdata", i), rf_wdata, (i == 4) ? 32'hC0DE : 32'h100 + 32'(i));
      @(negedge clk);
    end

    // Mid-operation reset: pending[9] set and an A write about to launch.
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    @(negedge clk);
    drive(1, 11, 32'h55, 0, 0, 0, 0, 0, 9, 11);
    #1;
    check("prerst.rs1_busy", 32'(rs1_busy), 32'h1);
    check("prerst.a_ready",  32'(a_ready),  32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.rf_wen",   32'(rf_wen),   32'h0);
    check("midrst.rf_waddr", 32'(rf_waddr), 32'h0);
    check("midrst.rf_wdata", rf_wdata,      32'h0);
    check("midrst.rs1_busy", 32'(rs1_busy), 32'h0);
    @(posedge clk); #1;
    check("rsthold.rf_wen",  32'(rf_wen),   32'h0);
    check("rsthold.rf_wdata", rf_wdata,     32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 11);
    rst_n = 1'b1;
    #1;
    check("postrst.rs1_busy", 32'(rs1_busy), 32'h0);
    check("postrst.rs2_busy", 32'(rs2_busy), 32'h0);
    @(posedge clk); #1;
    check("postrst.rf_wen",   32'(rf_wen),   32'h0);
    check("postrst.rf_waddr", 32'(rf_waddr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied cycles of requester A before A gets forced priority.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 a_valid / a_ready  in / out  1 / 1  requester A (execute result: ALU/CSR/PC+4) handshake.
REQ-005 a_addr / a_data  in / in  5 / 32  A destination register and data.
REQ-006 b_valid / b_ready  in / out  1 / 1  requester B (memory load return) handshake.
REQ-007 b_addr / b_data  in / in  5 / 32  B destination register and sign/zero-extended load data.
REQ-008 ld_issue / ld_issue_rd  in / in  1 / 5  load issued; mark rd pending.
REQ-009 rs1_addr / rs2_addr  in / in  5 / 5  source registers of the decoding instruction.
REQ-010 rs1_busy / rs2_busy  out / out  1 / 1  source not yet architecturally valid; decode must stall.
REQ-011 rf_wen / rf_waddr / rf_wdata  out / out / out  1 / 5 / 32  single register-file write port, registered.

Function
REQ-012 Transfer occurs on a requester when valid and ready are both high at a rising edge; at most one transfer per cycle.
REQ-013 Default priority: B over A; b_ready = 1 unless A is forced (REQ-016).
REQ-014 a_ready = !pending[a_addr] and (!b_valid or A forced).
REQ-015 starve_cnt increments when a_valid, !pending[a_addr], b_valid and A not granted; saturates at STARVE_LIMIT; clears on any A transfer or when a_valid is low.
REQ-016 A forced when starve_cnt == STARVE_LIMIT: b_ready = 0 and a_ready = !pending[a_addr] for that cycle.
REQ-017 Write latency 1: the transfer at edge N drives rf_wen=1, rf_waddr, rf_wdata from edge N to edge N+1; with no transfer rf_wen=0 and rf_waddr/rf_wdata hold.
REQ-018 Transfers with addr 0 complete the handshake but leave rf_wen=0.
REQ-019 pending is a 32-bit scoreboard; ld_issue with ld_issue_rd != 0 sets pending[ld_issue_rd]; a B transfer clears pending[b_addr].
REQ-020 Set and clear of the same bit in one cycle: set wins.
REQ-021 pending[0] is always 0.
REQ-022 rsX_busy = pending[rsX_addr] or (rf_wen and rf_waddr == rsX_addr and rsX_addr != 0), combinational.
REQ-023 pending[a_addr] blocks A (WAW ordering) even if B clears that bit in the same cycle; A proceeds the following cycle.
REQ-024 A B transfer whose b_addr is not pending is still written.

Reset
REQ-025 While rst_n low: pending=0, starve_cnt=0, rf_wen=0, rf_waddr=0, rf_wdata=0.
REQ-026 a_ready and b_ready follow REQ-013/014 from reset state.
REQ-027 Reset mid-operation discards in-flight writes and the scoreboard with no partial write.

Structure
REQ-028 Shared package holds XLEN=32, REG_ADDR_W=5 and the STARVE_LIMIT default.
REQ-029 Scoreboard (set/clear/lookup, REQ-019..022) is sub-module wb_scoreboard; arbitration, starvation counter and output register stay in wb_arbiter.

Verification
REQ-030 a_valid, a_addr=5, a_data=0x1234, no B -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234.
REQ-031 a_valid and b_valid same cycle, b_addr=3, a_addr=4 -> B written first, A written the following cycle.
REQ-032 b_valid held high for 6 cycles with a_valid, STARVE_LIMIT=4 -> A granted on the 5th cycle with b_ready=0; B resumes the next cycle.
REQ-033 ld_issue rd=7, then rs1_addr=7 -> rs1_busy=1 until the cycle after the B write to 7 completes; a_addr=7 held off until then.
REQ-034 a_addr=0, a_data=0xFFFF_FFFF -> a_ready=1, rf_wen stays 0; ld_issue rd=0 -> pending unchanged.
REQ-035 rst_n pulsed low with pending[9]=1 and A mid-transfer -> all outputs 0, rs busy cleared, no write.
